// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-port to valid/ready stream adapter with 2-entry skid buffer.
// Optional FIFO_RD_ADP_STATS_EN adds beat_total/stall_cycles counters.
module fifo_rd_stream_adapter #(
    parameter int FIFO_WIDTH = 16,
    parameter int PKT_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  err_clr,
    output logic                  err_underflow
`ifdef FIFO_RD_ADP_STATS_EN
    ,
    output logic [31:0]           beat_total,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

    logic [FIFO_WIDTH-1:0] slot [2];
    logic [1:0]            occ;
    logic                  inflight;
    logic                  head;
    logic                  tail;
    logic [CW-1:0]         beat_cnt;
    logic                  pop;
    logic                  cap;
    logic [2:0]            space;

    assign m_valid = (occ != 2'd0);
    assign m_data  = slot[head];
    assign m_last  = m_valid && (beat_cnt == LAST);
    assign pop     = m_valid && m_ready;
    assign cap     = inflight && !fifo_underflow;

    // occ + inflight never exceeds 2, so this cannot go negative
    assign space = 3'd2 + {2'b00, pop} - {1'b0, occ} - {2'b00, inflight};

    assign fifo_rd_en = rst_n && en && !fifo_empty && (space != 3'd0);

    // tail = head + occ (mod 2); with occ=2 this is the slot a pop vacates
    assign tail = head ^ occ[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0]       <= '0;
            slot[1]       <= '0;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            head          <= 1'b0;
            beat_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (cap) begin
                slot[tail] <= fifo_data_out;
            end
            if (pop) begin
                head <= ~head;
                if (beat_cnt == LAST) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            occ <= occ + {1'b0, cap} - {1'b0, pop};
            if (inflight && fifo_underflow) begin
                err_underflow <= 1'b1;
            end else if (err_clr) begin
                err_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_RD_ADP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_total   <= 32'd0;
            stall_cycles <= 32'd0;
        end else begin
            if (pop) begin
                beat_total <= beat_total + 32'd1;
            end
            if (m_valid && !m_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter with a behavioural FIFO
// model and a scoreboard of words expected on the stream.
module tb_fifo_rd_stream_adapter;

    localparam int W   = 16;
    localparam int PKT = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         fifo_empty;
    logic [W-1:0] fifo_data_out;
    logic         fifo_underflow;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         err_clr;
    logic         err_underflow;
`ifdef FIFO_RD_ADP_STATS_EN
    logic [31:0]  beat_total;
    logic [31:0]  stall_cycles;
`endif

    fifo_rd_stream_adapter #(.FIFO_WIDTH(W), .PKT_LEN(PKT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .err_clr        (err_clr),
        .err_underflow  (err_underflow)
`ifdef FIFO_RD_ADP_STATS_EN
        ,
        .beat_total     (beat_total),
        .stall_cycles   (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural upstream FIFO: registered data, one-cycle read latency
    logic [W-1:0] mem [256];
    int           wcnt = 0;
    int           rp = 0;
    logic         force_uf;

    assign fifo_empty = (rp == wcnt);

    initial begin
        fifo_data_out  = '0;
        fifo_underflow = 1'b0;
    end

    always @(posedge clk) begin
        fifo_underflow <= fifo_rd_en && (fifo_empty || force_uf);
        if (fifo_rd_en && !fifo_empty && !force_uf) begin
            fifo_data_out <= mem[rp[7:0]];
            rp            <= rp + 1;
        end
    end

    logic [W-1:0] sb [$];
    int           last_beats [$];
    int           nchk = 0;
    int           nerr = 0;
    int           tb_beats = 0;
    logic         popped = 1'b0;
    logic         have_prev = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;

    typedef struct {
        logic         en;
        logic         rdy;
        logic         rd;
        logic         v;
        logic [W-1:0] d;
        logic         l;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [W-1:0] w);
        mem[wcnt[7:0]] = w;
        wcnt++;
        sb.push_back(w);
    endtask

    task automatic monitor();
        logic [W-1:0] exp;
        popped = 1'b0;
        if (!rst_n) begin
            have_prev = 1'b0;
            return;
        end
        if (have_prev) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
            chk("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
            popped = 1'b1;
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 32'(m_data), 32'hDEAD);
            end else begin
                exp = sb.pop_front();
                chk("sb_data", 32'(m_data), 32'(exp));
            end
            chk("sb_last", 32'(m_last),
                32'((tb_beats % PKT) == PKT - 1));
            if (m_last) last_beats.push_back(tb_beats);
            tb_beats++;
        end
        have_prev = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b0;
        err_clr  = 1'b0;
        force_uf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        tb_beats  = 0;
        have_prev = 1'b0;
        last_beats.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int last;
        int n;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1A1A, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h2B2B, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h3C3C, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b0;
        err_clr  = 1'b0;
        force_uf = 1'b0;
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        apply_reset();

        // preload A,B,C then stream with the cycle table
        load(16'h1A1A);
        load(16'h2B2B);
        load(16'h3C3C);
        for (int i = 0; i < 6; i++) begin
            en      = tbl[i].en;
            m_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("t1_rd_c%0d", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
            chk($sformatf("t1_v_c%0d", i), 32'(m_valid), 32'(tbl[i].v));
            chk($sformatf("t1_l_c%0d", i), 32'(m_last), 32'(tbl[i].l));
            if (tbl[i].v) begin
                chk($sformatf("t1_d_c%0d", i), 32'(m_data), 32'(tbl[i].d));
            end
            monitor();
            @(posedge clk);
            #1;
        end

        // 20 words at full throughput, packet boundaries at beats 7, 15
        apply_reset();
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) load(16'h5000 + 16'(i));
        first = -1;
        last  = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (popped) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("t2_beats", 32'(tb_beats), 32'd20);
        chk("t2_span", 32'(last - first), 32'd19);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_nlast", 32'(last_beats.size()), 32'd2);
        if (last_beats.size() == 2) begin
            chk("t2_last0", 32'(last_beats[0]), 32'd7);
            chk("t2_last1", 32'(last_beats[1]), 32'd15);
        end

        // backpressure: buffer fills, reads stop, data holds
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(16'h7700 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) chk($sformatf("t3_rd_c%0d", i),
                            32'(fifo_rd_en), 32'd0);
            monitor();
            @(posedge clk);
            #1;
        end
        chk("t3_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        chk("t3_drained", 32'(sb.size()), 32'd0);
        tick();
        chk("t3_idle", 32'(m_valid), 32'd0);

        // en dropped right after one read issue
        en = 1'b0;
        load(16'hC001);
        load(16'hC002);
        load(16'hC003);
        @(negedge clk);
        chk("t4_no_rd", 32'(fifo_rd_en), 32'd0);
        monitor();
        @(posedge clk);
        #1;
        en = 1'b1;
        @(negedge clk);
        chk("t4_rd", 32'(fifo_rd_en), 32'd1);
        monitor();
        @(posedge clk);
        #1;
        en = 1'b0;
        n  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t4_rd_off_c%0d", i), 32'(fifo_rd_en), 32'd0);
            monitor();
            if (popped) n++;
            @(posedge clk);
            #1;
        end
        chk("t4_one_beat", 32'(n), 32'd1);
        chk("t4_sb_left", 32'(sb.size()), 32'd2);

        // forced underflow on the read's return cycle
        en       = 1'b1;
        force_uf = 1'b1;
        @(negedge clk);
        chk("t5_rd", 32'(fifo_rd_en), 32'd1);
        monitor();
        @(posedge clk);
        #1;
        en       = 1'b0;
        force_uf = 1'b0;
        @(negedge clk);
        chk("t5_err_c1", 32'(err_underflow), 32'd0);
        chk("t5_v_c1", 32'(m_valid), 32'd0);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5_err_c%0d", i), 32'(err_underflow), 32'd1);
            chk($sformatf("t5_v_c%0d", i), 32'(m_valid), 32'd0);
            monitor();
            @(posedge clk);
            #1;
        end
        err_clr = 1'b1;
        @(negedge clk);
        chk("t5_err_before_clr", 32'(err_underflow), 32'd1);
        monitor();
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t5_err_cleared", 32'(err_underflow), 32'd0);
        monitor();
        @(posedge clk);
        #1;
        chk("t5_sb_left", 32'(sb.size()), 32'd2);

        // fill the buffer, then reset mid-operation
        en      = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_full_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_data", 32'(m_data), 32'd0);
        chk("t6_rst_last", 32'(m_last), 32'd0);
        chk("t6_rst_rd", 32'(fifo_rd_en), 32'd0);
        sb.delete();
        have_prev = 1'b0;
        tb_beats  = 0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t6_idle_v%0d", i), 32'(m_valid), 32'd0);
            chk($sformatf("t6_idle_rd%0d", i), 32'(fifo_rd_en), 32'd0);
            monitor();
            @(posedge clk);
            #1;
        end
        load(16'hBEEF);
        @(negedge clk);
        chk("t6_new_rd", 32'(fifo_rd_en), 32'd1);
        monitor();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_new_v_c1", 32'(m_valid), 32'd0);
        monitor();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_new_v_c2", 32'(m_valid), 32'd1);
        monitor();
        @(posedge clk);
        #1;
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
